// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, FSM state
// encoding, ALU op classes and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } mc_state_t;

  // Per-state control bundle; pcwrite/branch/ne stay internal and feed pcen.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       half;
    logic       b;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode for the multicycle controller: (state, op_q) -> controls.
// ready gates the FETCH writes; it is tied high when memory is single-cycle.
module mc_out_decode
  import mips_pkg::*;
(
  input  mc_state_t  state,
  input  logic [5:0] op_q,
  input  logic       ready,
  output mc_ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = ready;
        ctrl.pcwrite = ready;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.half     = (op_q == OP_LH) || (op_q == OP_LB);
        ctrl.b        = (op_q == OP_LB);
      end
      // Held for the whole wait so the write stays stable until memory accepts it.
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
        ctrl.ne      = (op_q == OP_BNE);
      end
      IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        if (op_q == OP_ORI) begin
          ctrl.aluop   = ALUOP_OR;
          ctrl.zeroext = 1'b1;
        end
      end
      IMMWB: ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: state/op_q registers and next-state logic.
// Optional memory handshake (mem_ready port, wait states) under MC_MEM_READY_EN.
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
`ifdef MC_MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       half,
  output logic       b,
  output logic       illegal_op
);

  // state   | meaning
  // FETCH   | read instruction at PC, PC <= PC+4
  // DECODE  | register read, branch target precompute, dispatch on op
  // MEMADR  | effective address A + signimm
  // MEMRD   | data read at ALUOut
  // MEMWB   | load data into rt (LH/LB qualify width)
  // MEMWR   | store B at ALUOut
  // RTYPEEX | A funct B
  // ALUWB   | ALUOut into rd
  // BRANCH  | compare A-B, conditional PC <= target
  // IMMEX   | A op imm (add or zero-extended or)
  // IMMWB   | ALUOut into rt
  // JUMP    | PC <= jump target

  mc_state_t  state, state_n;
  logic [5:0] op_q;
  logic       ready;
  logic       illegal_n;
  mc_ctrl_t   ctrl;

`ifdef MC_MEM_READY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) op_q <= op;
    end
  end

  always_comb begin
    state_n   = state;
    illegal_n = 1'b0;
    case (state)
      FETCH:   if (ready) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_LH, OP_LB, OP_SW: state_n = MEMADR;
          OP_RTYPE:                   state_n = RTYPEEX;
          OP_BEQ, OP_BNE:             state_n = BRANCH;
          OP_ADDI, OP_ORI:            state_n = IMMEX;
          OP_J:                       state_n = JUMP;
          default: begin
            state_n   = FETCH;
            illegal_n = 1'b1;
          end
        endcase
      end
      MEMADR:  state_n = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (ready) state_n = MEMWB;
      MEMWB:   state_n = FETCH;
      MEMWR:   if (ready) state_n = FETCH;
      RTYPEEX: state_n = ALUWB;
      ALUWB:   state_n = FETCH;
      BRANCH:  state_n = FETCH;
      IMMEX:   state_n = IMMWB;
      IMMWB:   state_n = FETCH;
      JUMP:    state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state (state),
    .op_q  (op_q),
    .ready (ready),
    .ctrl  (ctrl)
  );

  // Outputs are forced low while reset is held so nothing fires mid-reset.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    aluop      = 3'b000;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    half       = 1'b0;
    b          = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      iord       = ctrl.iord;
      memwrite   = ctrl.memwrite;
      irwrite    = ctrl.irwrite;
      regdst     = ctrl.regdst;
      memtoreg   = ctrl.memtoreg;
      regwrite   = ctrl.regwrite;
      alusrca    = ctrl.alusrca;
      alusrcb    = ctrl.alusrcb;
      zeroext    = ctrl.zeroext;
      aluop      = ctrl.aluop;
      pcsrc      = ctrl.pcsrc;
      pcen       = ctrl.pcwrite | (ctrl.branch & (zero ^ ctrl.ne));
      half       = ctrl.half;
      b          = ctrl.b;
      illegal_op = illegal_n;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks every instruction class through
// its state sequence and compares all outputs against hand-written vectors.
module tb_mc_control_fsm;
  import mips_pkg::*;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       half;
    logic       b;
    logic       illegal_op;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [2:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen, half, b, illegal_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
`ifdef MC_MEM_READY_EN
    .mem_ready  (mem_ready),
`endif
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .zeroext    (zeroext),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .half       (half),
    .b          (b),
    .illegal_op (illegal_op)
  );

  localparam outs_t V_ZERO    = '0;
  localparam outs_t V_FETCH   = '{alusrcb:2'b01, irwrite:1'b1, pcen:1'b1, default:0};
  localparam outs_t V_DECODE  = '{alusrcb:2'b11, default:0};
  localparam outs_t V_ILLEGAL = '{alusrcb:2'b11, illegal_op:1'b1, default:0};
  localparam outs_t V_MEMADR  = '{alusrca:1'b1, alusrcb:2'b10, default:0};
  localparam outs_t V_MEMRD   = '{iord:1'b1, default:0};
  localparam outs_t V_WB_LW   = '{memtoreg:1'b1, regwrite:1'b1, default:0};
  localparam outs_t V_WB_LH   = '{memtoreg:1'b1, regwrite:1'b1, half:1'b1, default:0};
  localparam outs_t V_WB_LB   = '{memtoreg:1'b1, regwrite:1'b1, half:1'b1, b:1'b1, default:0};
  localparam outs_t V_MEMWR   = '{iord:1'b1, memwrite:1'b1, default:0};
  localparam outs_t V_RTYPEEX = '{alusrca:1'b1, aluop:3'b010, default:0};
  localparam outs_t V_ALUWB   = '{regdst:1'b1, regwrite:1'b1, default:0};
  localparam outs_t V_BR_TAKE = '{alusrca:1'b1, aluop:3'b001, pcsrc:2'b01, pcen:1'b1, default:0};
  localparam outs_t V_BR_NOT  = '{alusrca:1'b1, aluop:3'b001, pcsrc:2'b01, default:0};
  localparam outs_t V_IMM_ADD = '{alusrca:1'b1, alusrcb:2'b10, default:0};
  localparam outs_t V_IMM_OR  = '{alusrca:1'b1, alusrcb:2'b10, aluop:3'b011, zeroext:1'b1, default:0};
  localparam outs_t V_IMMWB   = '{regwrite:1'b1, default:0};
  localparam outs_t V_JUMP    = '{pcsrc:2'b10, pcen:1'b1, default:0};
  localparam outs_t V_FSTALL  = '{alusrcb:2'b01, default:0};

  task automatic check(input string tag, input logic [3:0] exp_state, input outs_t exp);
    outs_t obs;
    obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           zeroext, aluop, pcsrc, pcen, half, b, illegal_op};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp);
    end
    vectors++;
    assert (dut.state === exp_state) else begin
      miscompares++;
      $error("FAIL %s state: observed %0d expected %0d", tag, dut.state, exp_state);
    end
  endtask

  // Check the current cycle, then advance to the middle of the next one.
  task automatic cyc(input string tag, input logic [3:0] exp_state, input outs_t exp);
    check(tag, exp_state, exp);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    cyc("reset_hold", 4'd0, V_ZERO);
    check("reset_hold2", 4'd0, V_ZERO);
    reset = 1'b0;
    #1;

    op = OP_LW;
    cyc("lw_fetch", 4'd0, V_FETCH);
    cyc("lw_decode", 4'd1, V_DECODE);
    op = OP_SW;  // must be ignored after DECODE
    cyc("lw_memadr", 4'd2, V_MEMADR);
    cyc("lw_memrd", 4'd3, V_MEMRD);
    cyc("lw_memwb", 4'd4, V_WB_LW);

    op = OP_LB;
    cyc("lb_fetch", 4'd0, V_FETCH);
    cyc("lb_decode", 4'd1, V_DECODE);
    cyc("lb_memadr", 4'd2, V_MEMADR);
    cyc("lb_memrd", 4'd3, V_MEMRD);
    cyc("lb_memwb", 4'd4, V_WB_LB);

    op = OP_LH;
    cyc("lh_fetch", 4'd0, V_FETCH);
    cyc("lh_decode", 4'd1, V_DECODE);
    cyc("lh_memadr", 4'd2, V_MEMADR);
    cyc("lh_memrd", 4'd3, V_MEMRD);
    cyc("lh_memwb", 4'd4, V_WB_LH);

    op = OP_SW;
    cyc("sw_fetch", 4'd0, V_FETCH);
    cyc("sw_decode", 4'd1, V_DECODE);
    op = OP_LW;
    cyc("sw_memadr", 4'd2, V_MEMADR);
    cyc("sw_memwr", 4'd5, V_MEMWR);

    op = OP_RTYPE;
    cyc("rt_fetch", 4'd0, V_FETCH);
    cyc("rt_decode", 4'd1, V_DECODE);
    cyc("rt_ex", 4'd6, V_RTYPEEX);
    cyc("rt_wb", 4'd7, V_ALUWB);

    op = OP_BEQ; zero = 1'b1;
    cyc("beq1_fetch", 4'd0, V_FETCH);
    cyc("beq1_decode", 4'd1, V_DECODE);
    cyc("beq1_branch", 4'd8, V_BR_TAKE);

    op = OP_BEQ; zero = 1'b0;
    cyc("beq0_fetch", 4'd0, V_FETCH);
    cyc("beq0_decode", 4'd1, V_DECODE);
    cyc("beq0_branch", 4'd8, V_BR_NOT);

    op = OP_BNE; zero = 1'b1;
    cyc("bne1_fetch", 4'd0, V_FETCH);
    cyc("bne1_decode", 4'd1, V_DECODE);
    cyc("bne1_branch", 4'd8, V_BR_NOT);

    op = OP_BNE; zero = 1'b0;
    cyc("bne0_fetch", 4'd0, V_FETCH);
    cyc("bne0_decode", 4'd1, V_DECODE);
    cyc("bne0_branch", 4'd8, V_BR_TAKE);

    op = OP_ADDI;
    cyc("addi_fetch", 4'd0, V_FETCH);
    cyc("addi_decode", 4'd1, V_DECODE);
    cyc("addi_ex", 4'd9, V_IMM_ADD);
    cyc("addi_wb", 4'd10, V_IMMWB);

    op = OP_ORI;
    cyc("ori_fetch", 4'd0, V_FETCH);
    cyc("ori_decode", 4'd1, V_DECODE);
    cyc("ori_ex", 4'd9, V_IMM_OR);
    cyc("ori_wb", 4'd10, V_IMMWB);

    op = OP_J;
    cyc("j_fetch", 4'd0, V_FETCH);
    cyc("j_decode", 4'd1, V_DECODE);
    cyc("j_jump", 4'd11, V_JUMP);

    op = 6'b111111;
    cyc("ill_fetch", 4'd0, V_FETCH);
    cyc("ill_decode", 4'd1, V_ILLEGAL);
    op = OP_J;
    cyc("ill_refetch", 4'd0, V_FETCH);
    cyc("ill_after_decode", 4'd1, V_DECODE);
    cyc("ill_after_jump", 4'd11, V_JUMP);

    op = OP_SW;
    cyc("rst_sw_fetch", 4'd0, V_FETCH);
    cyc("rst_sw_decode", 4'd1, V_DECODE);
    cyc("rst_sw_memadr", 4'd2, V_MEMADR);
    check("rst_sw_memwr", 4'd5, V_MEMWR);
    reset = 1'b1;
    #1;
    cyc("rst_in_memwr", 4'd5, V_ZERO);
    check("rst_held", 4'd0, V_ZERO);
    reset = 1'b0;
    op = OP_J;
    #1;
    cyc("rst_release_fetch", 4'd0, V_FETCH);
    cyc("rst_release_decode", 4'd1, V_DECODE);
    cyc("rst_release_jump", 4'd11, V_JUMP);

`ifdef MC_MEM_READY_EN
    op = OP_SW;
    mem_ready = 1'b0;
    cyc("stall_fetch0", 4'd0, V_FSTALL);
    cyc("stall_fetch1", 4'd0, V_FSTALL);
    cyc("stall_fetch2", 4'd0, V_FSTALL);
    mem_ready = 1'b1;
    #1;
    cyc("stall_fetch_rdy", 4'd0, V_FETCH);
    cyc("stall_decode", 4'd1, V_DECODE);
    cyc("stall_memadr", 4'd2, V_MEMADR);
    mem_ready = 1'b0;
    cyc("stall_memwr0", 4'd5, V_MEMWR);
    cyc("stall_memwr1", 4'd5, V_MEMWR);
    mem_ready = 1'b1;
    cyc("stall_memwr_rdy", 4'd5, V_MEMWR);
    check("stall_done_fetch", 4'd0, V_FETCH);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
